// File: rtl/file2bus_pkg.sv
// Shared types and default widths for the file-stream to register-bus write controller.
package file2bus_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 18;
    localparam int WORD_W = ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WR   = 2'd2
    } state_t;

endpackage

// File: rtl/f2b_sync_fifo.sv
// Single-clock FIFO using read/write pointers plus an occupancy count.
// A push while full is accepted only when a pop happens on the same edge.
module f2b_sync_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage is deliberately left unreset; the count and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/file2bus_wr_ctrl.sv
// Buffers a 22-bit {addr,data} stream and replays each word as an acknowledged
// register-bus write, with req/gnt arbitration, bursting and ack timeout.
module file2bus_wr_ctrl #(
    parameter int ADDR_W      = file2bus_pkg::ADDR_W,
    parameter int DATA_W      = file2bus_pkg::DATA_W,
    parameter int FIFO_DEPTH  = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [ADDR_W+DATA_W-1:0] in_data,
    output logic                     bus_req,
    input  logic                     bus_gnt,
    output logic                     bus_wr,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic [DATA_W-1:0]        bus_wdata,
    input  logic                     bus_ack,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic                     err_timeout,
    output logic [15:0]              wr_count
);
    import file2bus_pkg::*;

    localparam int WORD_W = ADDR_W + DATA_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);

    state_t            state;
    logic [TO_W-1:0]   to_cnt;
    logic              seen_valid;
    logic [WORD_W-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              to_hit;
    logic              pop;
    logic              push_ok;
    logic              more_after_pop;

    assign to_hit  = (state == ST_WR) && !bus_ack && (to_cnt == TO_W'(ACK_TIMEOUT - 1));
    assign pop     = (state == ST_WR) && (bus_ack || to_hit);
    assign push_ok = in_valid && (!fifo_full || pop);
    // A burst continues when the pop leaves something behind, including a word landing this edge.
    assign more_after_pop = (fifo_count > CNT_W'(1)) || push_ok;

    f2b_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .pop   (pop),
        .din   (in_data),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus_addr  = (state == ST_WR) ? head[WORD_W-1:DATA_W] : '0;
    assign bus_wdata = (state == ST_WR) ? head[DATA_W-1:0]      : '0;
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            bus_req     <= 1'b0;
            bus_wr      <= 1'b0;
            to_cnt      <= '0;
            wr_count    <= '0;
            seen_valid  <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (in_valid) begin
                seen_valid <= 1'b1;
                done       <= 1'b0;
            end else if (seen_valid && fifo_empty && state == ST_IDLE) begin
                done <= 1'b1;
            end

            if (in_valid && !push_ok) overflow <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state   <= ST_REQ;
                        bus_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bus_gnt) begin
                        state  <= ST_WR;
                        bus_wr <= 1'b1;
                        to_cnt <= '0;
                    end
                end
                ST_WR: begin
                    if (bus_ack) begin
                        wr_count <= wr_count + 16'd1;
                        to_cnt   <= '0;
                        if (!more_after_pop) begin
                            state   <= ST_IDLE;
                            bus_req <= 1'b0;
                            bus_wr  <= 1'b0;
                        end
                    end else if (to_hit) begin
                        err_timeout <= 1'b1;
                        to_cnt      <= '0;
                        state       <= ST_IDLE;
                        bus_req     <= 1'b0;
                        bus_wr      <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    bus_req <= 1'b0;
                    bus_wr  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_file2bus_wr_ctrl.sv
// Directed bench for file2bus_wr_ctrl: single word, burst, overflow, timeout,
// reset mid-burst and full-FIFO push/pop collision.
module tb_file2bus_wr_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [21:0] in_data = '0;
    logic        bus_gnt = 1'b0;
    logic        bus_ack = 1'b0;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_addr;
    logic [17:0] bus_wdata;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        err_timeout;
    logic [15:0] wr_count;

    int tests = 0;
    int fails = 0;
    int nwr;
    int first_c;
    int last_c;
    int phases;
    logic req_q;
    logic [17:0] exp_data;

    file2bus_wr_ctrl #(
        .ADDR_W      (4),
        .DATA_W      (18),
        .FIFO_DEPTH  (8),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .bus_req     (bus_req),
        .bus_gnt     (bus_gnt),
        .bus_wr      (bus_wr),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .err_timeout (err_timeout),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = '0;
        bus_gnt  = 1'b0;
        bus_ack  = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_wr(input string tag, input int budget);
        int n;
        n = 0;
        while (!bus_wr && n < budget) begin
            tick();
            n++;
        end
        check(tag, bus_wr, 1'b1);
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_bus_wr", bus_wr, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_wr_count", wr_count, 16'd0);
        check("rst_bus_wdata", bus_wdata, 18'd0);

        // ---------------- single word ----------------
        bus_gnt  = 1'b1;
        bus_ack  = 1'b1;
        in_valid = 1'b1;
        in_data  = {4'h2, 18'h00ABC};
        tick();                                   // edge k
        in_valid = 1'b0;
        check("single_k_req", bus_req, 1'b0);
        check("single_k_busy", busy, 1'b1);
        tick();                                   // k+1
        check("single_k1_req", bus_req, 1'b1);
        check("single_k1_wr", bus_wr, 1'b0);
        tick();                                   // k+2
        check("single_k2_wr", bus_wr, 1'b1);
        check("single_k2_addr", bus_addr, 4'h2);
        check("single_k2_wdata", bus_wdata, 18'h00ABC);
        check("single_k2_count", wr_count, 16'd0);
        tick();                                   // k+3
        check("single_k3_count", wr_count, 16'd1);
        check("single_k3_wr", bus_wr, 1'b0);
        check("single_k3_done", done, 1'b0);
        tick();                                   // k+4
        check("single_k4_done", done, 1'b1);
        check("single_k4_busy", busy, 1'b0);

        // ---------------- burst of 16 ----------------
        do_reset();
        bus_ack = 1'b1;
        nwr = 0;
        first_c = -1;
        last_c = -1;
        phases = 0;
        req_q = 1'b0;
        for (int c = 0; c < 32; c++) begin
            in_valid = (c < 16);
            in_data  = {c[3:0], 18'h00100 + 18'(c)};
            bus_gnt  = (c >= 6);
            if (bus_wr) begin
                exp_data = 18'h00100 + 18'(nwr);
                check("burst_addr", bus_addr, nwr[3:0]);
                check("burst_wdata", bus_wdata, exp_data);
                if (nwr == 0) first_c = c;
                last_c = c;
                nwr++;
            end
            if (bus_req && !req_q) phases++;
            req_q = bus_req;
            tick();
        end
        check("burst_writes", nwr, 16);
        check("burst_b2b_span", last_c - first_c, 15);
        check("burst_req_phases", phases, 1);
        check("burst_wr_count", wr_count, 16'd16);
        check("burst_overflow", overflow, 1'b0);
        check("burst_done", done, 1'b1);

        // ---------------- overflow ----------------
        do_reset();
        bus_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = {i[3:0], 18'h03000 + 18'(i)};
            tick();
            if (i == 7) check("ovf_after_8th", overflow, 1'b0);
            if (i == 8) check("ovf_after_9th", overflow, 1'b1);
        end
        in_valid = 1'b0;
        bus_gnt  = 1'b1;
        nwr = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus_wr) begin
                exp_data = 18'h03000 + 18'(nwr);
                check("ovf_wdata", bus_wdata, exp_data);
                nwr++;
            end
            tick();
        end
        check("ovf_writes", nwr, 8);
        check("ovf_wr_count", wr_count, 16'd8);
        check("ovf_sticky", overflow, 1'b1);

        // ---------------- timeout ----------------
        do_reset();
        bus_gnt  = 1'b1;
        bus_ack  = 1'b0;
        in_valid = 1'b1;
        in_data  = {4'h7, 18'h11111};
        tick();                                   // e0
        in_valid = 1'b0;
        tick();                                   // e1 -> REQ
        tick();                                   // e2 -> WR
        check("to_in_wr", bus_wr, 1'b1);
        for (int i = 0; i < 14; i++) tick();      // e3..e16
        check("to_before_fire", err_timeout, 1'b0);
        check("to_still_wr", bus_wr, 1'b1);
        tick();                                   // e17: 15th WR cycle
        check("to_fired", err_timeout, 1'b1);
        check("to_wr_released", bus_wr, 1'b0);
        check("to_req_released", bus_req, 1'b0);
        check("to_popped_idle", busy, 1'b0);
        check("to_wr_count", wr_count, 16'd0);
        bus_ack  = 1'b1;
        in_valid = 1'b1;
        in_data  = {4'h9, 18'h22222};
        tick();
        in_valid = 1'b0;
        wait_wr("to_next_wait", 10);
        check("to_next_addr", bus_addr, 4'h9);
        check("to_next_wdata", bus_wdata, 18'h22222);
        tick();
        check("to_next_count", wr_count, 16'd1);
        check("to_sticky", err_timeout, 1'b1);

        // ---------------- reset mid-burst ----------------
        bus_ack = 1'b0;
        bus_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = {i[3:0], 18'h04000 + 18'(i)};
            tick();
        end
        in_valid = 1'b0;
        wait_wr("mid_wait", 10);
        check("mid_pre_err", err_timeout, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_req_drop", bus_req, 1'b0);
        check("mid_wr_drop", bus_wr, 1'b0);
        check("mid_wdata_zero", bus_wdata, 18'd0);
        check("mid_busy", busy, 1'b0);
        check("mid_count", wr_count, 16'd0);
        check("mid_err", err_timeout, 1'b0);
        check("mid_ovf", overflow, 1'b0);
        check("mid_done", done, 1'b0);
        tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("mid_idle_req", bus_req, 1'b0);
        check("mid_idle_busy", busy, 1'b0);
        check("mid_idle_done", done, 1'b0);
        bus_ack  = 1'b1;
        in_valid = 1'b1;
        in_data  = {4'h3, 18'h05555};
        tick();
        in_valid = 1'b0;
        wait_wr("mid_new_wait", 10);
        check("mid_new_wdata", bus_wdata, 18'h05555);
        tick();
        check("mid_new_count", wr_count, 16'd1);

        // ---------------- full with simultaneous push and pop ----------------
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = {i[3:0], 18'h05000 + 18'(i)};
            tick();
        end
        in_valid = 1'b0;
        bus_gnt  = 1'b1;
        tick();
        check("coll_wr", bus_wr, 1'b1);
        check("coll_head", bus_wdata, 18'h05000);
        bus_ack  = 1'b1;
        in_valid = 1'b1;
        in_data  = {4'hF, 18'h2BEEF};
        tick();
        in_valid = 1'b0;
        check("coll_no_ovf", overflow, 1'b0);
        check("coll_count1", wr_count, 16'd1);
        nwr = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus_wr) begin
                exp_data = (nwr < 7) ? 18'h05001 + 18'(nwr) : 18'h2BEEF;
                check("coll_wdata", bus_wdata, exp_data);
                nwr++;
            end
            tick();
        end
        check("coll_writes", nwr, 8);
        check("coll_wr_count", wr_count, 16'd9);
        check("coll_ovf_end", overflow, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/file2bus_wr_ctrl.md
# file2bus_wr_ctrl

Write controller placed between the file-stream source (valid plus a 22-bit `{addr[3:0], data[17:0]}` word per clock, no backpressure) and a shared register bus. It absorbs the stream in a small FIFO, arbitrates for the bus with a req/gnt handshake, and issues one write per buffered word, waiting for an acknowledge before popping the word. It reports progress, stream completion, FIFO overflow and write timeout to the testbench or host.

## Interface
- `ADDR_W`, default 4: register address width.
- `DATA_W`, default 18: write-data width.
- `FIFO_DEPTH`, default 8: buffer entries. Must be a power of 2 and at least 2.
- `ACK_TIMEOUT`, default 15: number of cycles in WR without `bus_ack` before the word is abandoned.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: stream word present this cycle.
- `in_data` in ADDR_W+DATA_W: `{addr, data}`, with addr in the MSBs.
- `bus_req` out 1: bus request.
- `bus_gnt` in 1: bus grant. Sampled only in REQ.
- `bus_wr` out 1: write strobe.
- `bus_addr` out ADDR_W: write address.
- `bus_wdata` out DATA_W: write data.
- `bus_ack` in 1: write accepted. Sampled only in WR.
- `busy` out 1: high when the state is not IDLE or the FIFO is not empty.
- `done` out 1: sticky stream-complete flag.
- `overflow` out 1: sticky flag, set when a word is dropped because the FIFO is full.
- `err_timeout` out 1: sticky flag, set when a write is abandoned.
- `wr_count` out 16: count of acknowledged writes. Wraps 0xFFFF→0.

## Operation
- Push: a word is pushed on every edge with `in_valid`=1, unless the FIFO is full and no pop occurs on that edge. If full and no pop, the word is dropped and `overflow` is set. If a push and a pop occur on the same edge while full, the push succeeds.
- FSM has three states:
  - IDLE: `bus_req`=0 and `bus_wr`=0. Go to REQ if the FIFO is not empty.
  - REQ: `bus_req`=1. Go to WR when `bus_gnt`=1; otherwise stay.
  - WR: `bus_req`=1, `bus_wr`=1. `bus_addr`/`bus_wdata` = FIFO head, in_data[ADDR_W+DATA_W-1:DATA_W] / in_data[DATA_W-1:0].
    - On `bus_ack`: pop the word and increment `wr_count`. Stay in WR (burst, bus kept) if a word remains after the pop, counting a same-edge push. Otherwise go to IDLE.
    - If no ack within the timeout: pop, set `err_timeout`, go to IDLE (bus released). `wr_count` is not incremented.
- Timeout counter: cleared on entry to WR and on every ack. The timeout fires on the ACK_TIMEOUT-th consecutive WR cycle without an ack.
- Drop of `bus_gnt` during WR is ignored. The controller holds the bus until the burst ends.
- `bus_addr`/`bus_wdata` are 0 outside WR.
- `done`:
  - Set on an edge where the controller has seen at least one `in_valid` since reset or the last clear, the current `in_valid`=0, the FIFO is empty, and the state is IDLE.
  - Cleared on any edge with `in_valid`=1.
- Reset values: all outputs are 0, the FIFO is empty, and the state is IDLE. Reset mid-burst aborts immediately; the bus is released asynchronously.

## Timing
- Word sampled at edge k. The FIFO is non-empty after k.
- IDLE→REQ at edge k+1, so `bus_req` is high after k+1.
- With `bus_gnt` high at k+2, the state enters WR and `bus_wr` is high after k+2.
- With `bus_ack` high at k+3, the word is popped and `wr_count` increments after k+3.
- Best case is 3 cycles from input sample to the acknowledged write.
- Burst throughput: 1 word per cycle while `bus_ack` is held high and the FIFO is not empty.
- All outputs are registered (Moore) except `bus_addr`/`bus_wdata`, which come from the FIFO head read mux gated by state.
- Sticky flags take effect one edge after the triggering event.

## Structure
- The package `file2bus_pkg` holds:
  - the state enum (IDLE/REQ/WR);
  - the default widths `ADDR_W`=4 and `DATA_W`=18;
  - the word-type width `WORD_W` = `ADDR_W+DATA_W`.
- Sub-module `f2b_sync_fifo`: parameterised width and depth, async active-low reset, and ports push, pop, din, dout (head), full, empty, count. It uses a pointer-plus-count design with no extra wrap bit.
- The top level contains the FSM, the timeout counter, `wr_count` and the sticky flags.

## Test plan
- Single word: push 0x2_00ABC with `bus_gnt` and `bus_ack` tied high. Expect:
  - `bus_req` at cycle k+1;
  - `bus_wr` with `bus_addr`=2 and `bus_wdata`=0x00ABC at k+2;
  - `wr_count`=1 at k+3;
  - `done`=1 one edge after IDLE is reached with `in_valid` low.
- Burst: 16 consecutive words with addresses 0..15, grant delayed 5 cycles and ack always high. Expect one REQ phase, then 16 back-to-back writes in order, `wr_count`=16, and no overflow.
- Overflow: `FIFO_DEPTH`=8, no grant, and 10 words pushed. Expect `overflow`=1 after the 9th push. After the grant, exactly 8 writes occur (words 1–8) and `wr_count`=8.
- Timeout: grant given and ack never given. Expect `err_timeout`=1 after 15 WR cycles, the word popped, the state in IDLE, and `wr_count` unchanged. The next word is written normally.
- Full with simultaneous push and pop: the FIFO is full and `bus_ack` coincides with `in_valid`. Expect no overflow and the new word written last.
- Reset mid-burst: assert `rst_n`=0 asynchronously during WR with 4 words queued. Expect `bus_req`/`bus_wr` to drop immediately and all flags, counts and the FIFO to be 0. After release, the controller stays in IDLE until new input arrives.
